// File: rtl/decode_stage_if.sv
// Fetch/write-back/execute signal bundle around the decode stage.
// slave: the decode stage's view; master: the surrounding pipeline's view.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_out;
    logic            illegal;

    modport slave (
        input  flush, in_valid, instr, pc_in, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, rs1_data, rs2_data, rs1, rs2, rd,
               opcode, funct3, funct7, imm, pc_out, illegal
    );

    modport master (
        output flush, in_valid, instr, pc_in, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, rs1_data, rs2_data, rs1, rs2, rd,
               opcode, funct3, funct7, imm, pc_out, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32/RV64 instruction decode stage: register file, immediate generation, one output slot.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data into captured operands.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam int         IDX_W     = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins);
        logic signed [31:0] raw;
        raw = '0;
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                raw = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:
                raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:
                raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                raw = {ins[31:12], 12'b0};
            OP_JAL:
                raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                raw = '0;
        endcase
        return XLEN'(raw);
    endfunction

    logic [XLEN-1:0] regs [REG_COUNT];

    logic [4:0]             rs1_p0, rs2_p0, rd_p0;
    logic [6:0]             opcode_p0;
    logic                   uses_rs1_p0, uses_rs2_p0, uses_rd_p0, known_p0;
    logic                   illegal_p0, wb_hit_p0, capture_p0;
    logic [XLEN-1:0]        rs1_raw_p0, rs2_raw_p0, rs1_data_p0, rs2_data_p0;
    logic signed [XLEN-1:0] imm_p0;

    logic                   vld_p1;
    logic [XLEN-1:0]        rs1_data_p1, rs2_data_p1, pc_p1;
    logic [4:0]             rs1_p1, rs2_p1, rd_p1;
    logic [6:0]             opcode_p1, funct7_p1;
    logic [2:0]             funct3_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic                   illegal_p1;

    assign rs1_p0     = bus.instr[19:15];
    assign rs2_p0     = bus.instr[24:20];
    assign rd_p0      = bus.instr[11:7];
    assign opcode_p0  = bus.instr[6:0];
    assign imm_p0     = imm_gen(bus.instr);
    assign wb_hit_p0  = bus.wb_en && (bus.wb_rd != 5'd0) && idx_ok(bus.wb_rd);
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign capture_p0 = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        uses_rs1_p0 = 1'b0;
        uses_rs2_p0 = 1'b0;
        uses_rd_p0  = 1'b0;
        known_p0    = 1'b1;
        case (opcode_p0)
            OP_R: begin
                uses_rs1_p0 = 1'b1;
                uses_rs2_p0 = 1'b1;
                uses_rd_p0  = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                uses_rs1_p0 = 1'b1;
                uses_rd_p0  = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1_p0 = 1'b1;
                uses_rs2_p0 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL:
                uses_rd_p0 = 1'b1;
            default:
                known_p0 = 1'b0;
        endcase
    end

    // Operand read; without the bypass a same-cycle write is seen one capture later.
    always_comb begin
        rs1_raw_p0 = '0;
        rs2_raw_p0 = '0;
        if (rs1_p0 != 5'd0 && idx_ok(rs1_p0))
            rs1_raw_p0 = regs[rs1_p0[IDX_W-1:0]];
        if (rs2_p0 != 5'd0 && idx_ok(rs2_p0))
            rs2_raw_p0 = regs[rs2_p0[IDX_W-1:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_hit_p0 && bus.wb_rd == rs1_p0)
            rs1_raw_p0 = bus.wb_data;
        if (wb_hit_p0 && bus.wb_rd == rs2_p0)
            rs2_raw_p0 = bus.wb_data;
`endif
    end

    always_comb begin
        illegal_p0 = (bus.instr[1:0] != 2'b11) || !known_p0
                   || (uses_rs1_p0 && !idx_ok(rs1_p0))
                   || (uses_rs2_p0 && !idx_ok(rs2_p0))
                   || (uses_rd_p0  && !idx_ok(rd_p0));
        rs1_data_p0 = (illegal_p0 || !uses_rs1_p0) ? '0 : rs1_raw_p0;
        rs2_data_p0 = (illegal_p0 || !uses_rs2_p0) ? '0 : rs2_raw_p0;
    end

    // ---- p0 -> p1: output slot and register file ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            pc_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            opcode_p1   <= '0;
            funct3_p1   <= '0;
            funct7_p1   <= '0;
            imm_p1      <= '0;
            illegal_p1  <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else begin
            if (wb_hit_p0)
                regs[bus.wb_rd[IDX_W-1:0]] <= bus.wb_data;
            if (bus.flush) begin
                vld_p1 <= 1'b0;
            end else if (capture_p0) begin
                vld_p1      <= 1'b1;
                rs1_data_p1 <= rs1_data_p0;
                rs2_data_p1 <= rs2_data_p0;
                pc_p1       <= bus.pc_in;
                rs1_p1      <= rs1_p0;
                rs2_p1      <= rs2_p0;
                rd_p1       <= rd_p0;
                opcode_p1   <= opcode_p0;
                funct3_p1   <= bus.instr[14:12];
                funct7_p1   <= bus.instr[31:25];
                imm_p1      <= imm_p0;
                illegal_p1  <= illegal_p0;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.rs1_data  = rs1_data_p1;
    assign bus.rs2_data  = rs2_data_p1;
    assign bus.rs1       = rs1_p1;
    assign bus.rs2       = rs2_p1;
    assign bus.rd        = rd_p1;
    assign bus.opcode    = opcode_p1;
    assign bus.funct3    = funct3_p1;
    assign bus.funct7    = funct7_p1;
    assign bus.imm       = imm_p1;
    assign bus.pc_out    = pc_p1;
    assign bus.illegal   = illegal_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-register instance plus a 16-register instance.
module tb_decode_stage;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_stage_if #(.XLEN(32)) b();
    decode_stage_if #(.XLEN(32)) b16();

    decode_stage #(.XLEN(32), .REG_COUNT(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    decode_stage #(.XLEN(32), .REG_COUNT(16)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_X3_X1_X2  = 32'h002081B3;
    localparam logic [31:0] ADDI_X1_M1    = 32'hFFF00093;
    localparam logic [31:0] SW_X2_8_X1    = 32'h0020A423;
    localparam logic [31:0] LUI_X5        = 32'h123452B7;
    localparam logic [31:0] BEQ_X1_X2_16  = 32'h00208863;
    localparam logic [31:0] JAL_X1_M4     = 32'hFFDFF0EF;
    localparam logic [31:0] ADD_X8_X7_X7  = 32'h00738433;
    localparam logic [31:0] ADD_X17_X1_X2 = 32'h002088B3;

    logic [31:0] exp_bypass;

    initial begin
        reset = 1'b0;
        b.flush = 0;   b.in_valid = 0;   b.instr = '0;   b.pc_in = '0;
        b.wb_en = 0;   b.wb_rd = '0;     b.wb_data = '0; b.out_ready = 1;
        b16.flush = 0; b16.in_valid = 0; b16.instr = '0; b16.pc_in = '0;
        b16.wb_en = 0; b16.wb_rd = '0;   b16.wb_data = '0; b16.out_ready = 1;
        step();
        step();
        reset = 1'b1;

        check("rst_out_valid", b.out_valid, 0);
        check("rst_in_ready", b.in_ready, 1);
        check("rst_rs1_data", b.rs1_data, 0);
        check("rst_imm", b.imm, 0);
        check("rst_rd", b.rd, 0);
        check("rst_pc_out", b.pc_out, 0);
        check("rst_illegal", b.illegal, 0);

        // register writes: x1=5, x2=10 (x1=3, x2=4 on the 16-entry instance)
        b.wb_en = 1;   b.wb_rd = 1;   b.wb_data = 5;
        b16.wb_en = 1; b16.wb_rd = 1; b16.wb_data = 3;
        step();
        b.wb_rd = 2;   b.wb_data = 10;
        b16.wb_rd = 2; b16.wb_data = 4;
        step();
        b.wb_en = 0; b16.wb_en = 0;

        b.instr = ADD_X3_X1_X2; b.pc_in = 32'h100; b.in_valid = 1;
        b16.instr = ADD_X17_X1_X2; b16.in_valid = 1;
        step();
        check("add_out_valid", b.out_valid, 1);
        check("add_rs1_data", b.rs1_data, 5);
        check("add_rs2_data", b.rs2_data, 10);
        check("add_rd", b.rd, 3);
        check("add_rs1", b.rs1, 1);
        check("add_rs2", b.rs2, 2);
        check("add_opcode", b.opcode, 7'h33);
        check("add_imm", b.imm, 0);
        check("add_illegal", b.illegal, 0);
        check("add_pc_out", b.pc_out, 32'h100);
        check("r16_x17_illegal", b16.illegal, 1);
        check("r16_x17_rs1_data", b16.rs1_data, 0);
        check("r16_x17_rs2_data", b16.rs2_data, 0);
        check("r16_x17_rd", b16.rd, 17);

        b.in_valid = 0;
        b16.instr = ADD_X3_X1_X2;
        step();
        check("drain_out_valid", b.out_valid, 0);
        check("r16_add_rs1_data", b16.rs1_data, 3);
        check("r16_add_rs2_data", b16.rs2_data, 4);
        check("r16_add_illegal", b16.illegal, 0);
        b16.in_valid = 0;

        // back-to-back immediates
        b.in_valid = 1; b.instr = ADDI_X1_M1;
        step();
        check("addi_imm", b.imm, 32'hFFFF_FFFF);
        check("addi_rs2_data", b.rs2_data, 0);
        check("addi_rs1_data", b.rs1_data, 0);
        check("addi_rd", b.rd, 1);
        b.instr = SW_X2_8_X1;
        step();
        check("sw_out_valid", b.out_valid, 1);
        check("sw_imm", b.imm, 8);
        check("sw_rs1_data", b.rs1_data, 5);
        check("sw_rs2_data", b.rs2_data, 10);
        b.instr = LUI_X5;
        step();
        check("lui_imm", b.imm, 32'h1234_5000);
        check("lui_rs1_data", b.rs1_data, 0);
        check("lui_rd", b.rd, 5);
        b.instr = BEQ_X1_X2_16;
        step();
        check("beq_imm", b.imm, 16);
        check("beq_rs2_data", b.rs2_data, 10);
        b.instr = JAL_X1_M4;
        step();
        check("jal_imm", b.imm, 32'hFFFF_FFFC);
        check("jal_rs1_data", b.rs1_data, 0);
        b.in_valid = 0;
        step();

        // backpressure
        b.out_ready = 0; b.in_valid = 1; b.instr = ADD_X3_X1_X2; b.pc_in = 32'h200;
        step();
        b.instr = ADDI_X1_M1; b.pc_in = 32'h204;
        #1;
        check("bp_in_ready", b.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", b.out_valid, 1);
            check("bp_hold_pc", b.pc_out, 32'h200);
            check("bp_hold_rd", b.rd, 3);
            check("bp_hold_rs1_data", b.rs1_data, 5);
            check("bp_hold_in_ready", b.in_ready, 0);
        end
        b.out_ready = 1;
        #1;
        check("bp_release_in_ready", b.in_ready, 1);
        step();
        check("bp_next_valid", b.out_valid, 1);
        check("bp_next_pc", b.pc_out, 32'h204);
        check("bp_next_imm", b.imm, 32'hFFFF_FFFF);
        b.in_valid = 0;
        step();

        // flush with capture and write-back of x7
        b.in_valid = 1; b.instr = ADD_X3_X1_X2; b.flush = 1;
        b.wb_en = 1; b.wb_rd = 7; b.wb_data = 32'h55;
        step();
        check("flush_out_valid", b.out_valid, 0);
        b.flush = 0; b.wb_en = 0; b.instr = ADD_X8_X7_X7;
        step();
        check("flush_wb_rs1_data", b.rs1_data, 32'h55);
        check("flush_wb_rs2_data", b.rs2_data, 32'h55);

        // same-cycle write-back to x1 during capture
`ifdef DECODE_WB_BYPASS_EN
        exp_bypass = 32'hAA;
`else
        exp_bypass = 32'h5;
`endif
        b.instr = ADD_X3_X1_X2; b.wb_en = 1; b.wb_rd = 1; b.wb_data = 32'hAA;
        step();
        check("bypass_rs1_data", b.rs1_data, {32'h0, exp_bypass});
        check("bypass_rs2_data", b.rs2_data, 10);
        b.wb_en = 0;
        step();
        check("after_wb_rs1_data", b.rs1_data, 32'hAA);

        // x0 is never written
        b.in_valid = 0; b.wb_en = 1; b.wb_rd = 0; b.wb_data = 32'h1;
        step();
        b.wb_en = 0; b.in_valid = 1; b.instr = ADDI_X1_M1;
        step();
        check("x0_rs1_data", b.rs1_data, 0);

        b.instr = 32'h0000_0000;
        step();
        check("zero_instr_illegal", b.illegal, 1);
        check("zero_instr_rs1_data", b.rs1_data, 0);

        // reset while stalled drops the bundle and clears registers
        b.out_ready = 0; b.instr = ADD_X3_X1_X2;
        step();
        check("stall_valid", b.out_valid, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_stall_out_valid", b.out_valid, 0);
        check("rst_stall_rd", b.rd, 0);
        check("rst_stall_rs1_data", b.rs1_data, 0);
        b.out_ready = 1;
        step();
        check("post_rst_rs1_data", b.rs1_data, 0);
        check("post_rst_rs2_data", b.rs2_data, 0);
        check("post_rst_out_valid", b.out_valid, 1);
        b.in_valid = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
